// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared widths, EXE correction codes and in-flight queue entry type
package pc_redirect_unit_pkg;
    localparam int unsigned AW_DEF    = 10;
    localparam int unsigned DEPTH_DEF = 4;
    localparam logic [1:0]  CORR_CNI  = 2'b10;
    localparam logic [1:0]  CORR_PBT  = 2'b11;
    typedef struct packed {
        logic [AW_DEF-1:0] pc;
        logic              pred;
        logic [AW_DEF-1:0] pbt;
    } entry_t;
endpackage

// File: rtl/inflight_queue.sv
// inflight_queue: circular buffer of fetched words with push, pop, clear and drop of the youngest entry
module inflight_queue
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic                       drop_i,
    input  entry_t                     din_i,
    output entry_t                     head_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, wr_idx;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    // a dropped youngest slot is immediately reused by the push in the same cycle
    always_comb begin
        wr_idx  = tail_q - PW'(drop_i);
        head_d  = clear_i ? '0 : head_q + PW'(pop_i);
        tail_d  = clear_i ? '0 : wr_idx + PW'(push_i);
        count_d = clear_i ? '0 : count_q - CW'(pop_i) - CW'(drop_i) + CW'(push_i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_idx] <= din_i;
    end
    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with IF/ID/EXE redirect priority, in-flight tracking, flush and mispredict stats
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   if_prediction,
    input  logic [AW-1:0]          if_PBT,
    input  logic                   id_is_jump,
    input  logic                   id_jump_in_bht,
    input  logic [AW-1:0]          id_branchtarget,
    input  logic                   exe_valid,
    input  logic [AW-1:0]          exe_PC,
    input  logic [1:0]             exe_correction,
    input  logic [AW-1:0]          exe_PBT,
    input  logic [AW-1:0]          exe_CNI,
    output logic [AW-1:0]          pc,
    output logic                   flush,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   trk_error,
    output logic [CNT_W-1:0]       mispredict_cnt
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    logic             advance, exe_redir, id_redir, pop_req, pop, drop, push_req, push;
    logic [CW-1:0]    count, cnt_after_pop;
    entry_t           head, din;
    logic [AW-1:0]    pc_q, pc_d;
    logic             flush_hold_q, flush_hold_d, trk_error_q, trk_error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_head;
    assign din = '{pc: pc_q, pred: if_prediction, pbt: if_PBT};
    assign unused_head = ^{head.pred, head.pbt};
    // a full queue only refuses a push when nothing left it this cycle
    always_comb begin
        advance       = en && !stall;
        exe_redir     = advance && exe_correction[1];
        id_redir      = advance && !exe_correction[1] && id_is_jump && !id_jump_in_bht;
        pop_req       = advance && exe_valid;
        pop           = pop_req && count != '0;
        cnt_after_pop = count - CW'(pop);
        drop          = id_redir && cnt_after_pop != '0;
        push_req      = advance && !exe_redir;
        push          = push_req && (cnt_after_pop - CW'(drop)) != CW'(DEPTH);
        pc_d          = !advance                    ? pc_q :
                        exe_correction == CORR_CNI  ? exe_CNI :
                        exe_correction == CORR_PBT  ? exe_PBT :
                        id_redir                    ? id_branchtarget :
                        if_prediction               ? if_PBT : pc_q + AW'(1);
        flush_hold_d  = advance ? exe_redir : flush_hold_q;
        cnt_d         = cnt_q + CNT_W'(exe_redir && cnt_q != '1);
        trk_error_d   = trk_error_q || (pop_req && count == '0) ||
                        (pop && head.pc != exe_PC) || (push_req && !push);
    end
    always_ff @(posedge CLK) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            flush_hold_q <= 1'b0;
            trk_error_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            flush_hold_q <= flush_hold_d;
            trk_error_q  <= trk_error_d;
            cnt_q        <= cnt_d;
        end
    end
    inflight_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (CLK),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (exe_redir),
        .drop_i  (drop),
        .din_i   (din),
        .head_o  (head),
        .count_o (count)
    );
    assign pc             = pc_q;
    assign flush          = exe_redir || flush_hold_q;
    assign q_count        = count;
    assign trk_error      = trk_error_q;
    assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and randomized checks of pc_redirect_unit against a queue-based reference model
module tb_pc_redirect_unit;
    import pc_redirect_unit_pkg::*;
    localparam int AW = 10;
    localparam int DEPTH = 4;
    logic           CLK = 1'b0;
    logic           rst, en, stall, if_prediction, id_is_jump, id_jump_in_bht, exe_valid;
    logic [AW-1:0]  if_PBT, id_branchtarget, exe_PC, exe_PBT, exe_CNI, pc;
    logic [1:0]     exe_correction;
    logic           flush, trk_error;
    logic [2:0]     q_count;
    logic [15:0]    mispredict_cnt;
    int             checks = 0, failures = 0;
    bit             chk_en = 0;
    entry_t         m_q[$];
    logic [AW-1:0]  m_pc = '0;
    bit             m_hold = 0, m_err = 0;
    logic [15:0]    m_cnt = '0;

    always #5 CLK = ~CLK;

    pc_redirect_unit dut (
        .CLK(CLK), .rst(rst), .en(en), .stall(stall),
        .if_prediction(if_prediction), .if_PBT(if_PBT),
        .id_is_jump(id_is_jump), .id_jump_in_bht(id_jump_in_bht), .id_branchtarget(id_branchtarget),
        .exe_valid(exe_valid), .exe_PC(exe_PC), .exe_correction(exe_correction),
        .exe_PBT(exe_PBT), .exe_CNI(exe_CNI),
        .pc(pc), .flush(flush), .q_count(q_count), .trk_error(trk_error), .mispredict_cnt(mispredict_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: the queue holds fetched words oldest-first; applied at each clock edge
    task automatic model_step();
        bit     ex, idr;
        entry_t e;
        if (rst) begin
            m_pc = '0; m_q.delete(); m_hold = 0; m_err = 0; m_cnt = '0;
        end else if (en && !stall) begin
            ex  = exe_correction[1];
            idr = !ex && id_is_jump && !id_jump_in_bht;
            e   = '{pc: m_pc, pred: if_prediction, pbt: if_PBT};
            if (exe_valid) begin
                if (m_q.size() == 0) m_err = 1;
                else begin
                    if (m_q[0].pc != exe_PC) m_err = 1;
                    void'(m_q.pop_front());
                end
            end
            if (ex) m_q.delete();
            else begin
                if (idr && m_q.size() > 0) void'(m_q.pop_back());
                if (m_q.size() == DEPTH) m_err = 1;
                else m_q.push_back(e);
            end
            m_hold = ex;
            if (ex && m_cnt != 16'hFFFF) m_cnt++;
            m_pc = exe_correction == 2'b10 ? exe_CNI :
                   exe_correction == 2'b11 ? exe_PBT :
                   idr ? id_branchtarget :
                   if_prediction ? if_PBT : AW'((int'(m_pc) + 1) % 1024);
        end
    endtask

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("m_pc", 32'(pc), 32'(m_pc));
            chk("m_q_count", 32'(q_count), 32'(m_q.size()));
            chk("m_trk_error", 32'(trk_error), 32'(m_err));
            chk("m_mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
            chk("m_flush", 32'(flush), 32'((en && !stall && exe_correction[1]) || m_hold));
        end
    end

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 0; en = 1; stall = 0; if_prediction = 0; if_PBT = '0;
        id_is_jump = 0; id_jump_in_bht = 0; id_branchtarget = '0;
        exe_valid = 0; exe_PC = '0; exe_correction = 2'b00; exe_PBT = '0; exe_CNI = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic rand_inputs(input bit clean);
        int r;
        en = ($urandom % 8) != 0;
        stall = ($urandom % 5) == 0;
        if_prediction = ($urandom % 4) == 0;
        if_PBT = AW'($urandom);
        id_is_jump = ($urandom % 6) == 0;
        id_jump_in_bht = $urandom % 2 == 1;
        id_branchtarget = AW'($urandom);
        r = int'($urandom % 10);
        exe_correction = r == 7 ? 2'b01 : r == 8 ? 2'b10 : r == 9 ? 2'b11 : 2'b00;
        exe_PBT = AW'($urandom);
        exe_CNI = AW'($urandom);
        if (clean) begin
            exe_valid = m_q.size() >= 3 || (m_q.size() > 0 && $urandom % 2 == 1);
            exe_PC = m_q.size() > 0 ? m_q[0].pc : AW'($urandom);
        end else begin
            exe_valid = ($urandom % 3) == 0;
            exe_PC = (m_q.size() > 0 && $urandom % 4 != 0) ? m_q[0].pc : AW'($urandom);
            rst = ($urandom % 150) == 0;
        end
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        rst = 0;
        chk_en = 1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_q_count", 32'(q_count), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_trk_error", 32'(trk_error), 0);
        chk("rst_cnt", 32'(mispredict_cnt), 0);

        for (int i = 0; i < 6; i++) begin
            exe_valid = i >= 3;
            exe_PC = AW'(i - 3);
            step();
            chk("seq_pc", 32'(pc), 32'(i + 1));
            chk("seq_q_count", 32'(q_count), i < 3 ? 32'(i + 1) : 32'd3);
        end
        exe_valid = 0;
        chk("seq_trk_error", 32'(trk_error), 0);

        do_reset();
        exe_correction = CORR_CNI; exe_CNI = 10'd5;
        step();
        exe_correction = 2'b00;
        chk("if_setup_pc", 32'(pc), 5);
        if_prediction = 1; if_PBT = 10'h040;
        step();
        if_prediction = 0;
        chk("if_taken_pc", 32'(pc), 32'h040);
        chk("if_taken_q_count", 32'(q_count), 1);
        exe_valid = 1; exe_PC = 10'd5;
        step();
        exe_valid = 0;
        chk("if_entry_trk", 32'(trk_error), 0);
        chk("if_after_pc", 32'(pc), 32'h041);

        do_reset();
        exe_correction = CORR_PBT; exe_PBT = 10'h080;
        id_is_jump = 1; id_jump_in_bht = 0; id_branchtarget = 10'h100;
        #1 chk("exe_flush_now", 32'(flush), 1);
        step();
        exe_correction = 2'b00; id_is_jump = 0; stall = 1;
        #1;
        chk("exe_prio_pc", 32'(pc), 32'h080);
        chk("exe_prio_q_count", 32'(q_count), 0);
        chk("exe_prio_cnt", 32'(mispredict_cnt), 1);
        chk("exe_flush_stall", 32'(flush), 1);
        step(); step();
        chk("exe_flush_held", 32'(flush), 1);
        chk("exe_stall_pc", 32'(pc), 32'h080);
        stall = 0;
        #1 chk("exe_flush_second", 32'(flush), 1);
        step();
        chk("exe_flush_done", 32'(flush), 0);
        chk("exe_resume_pc", 32'(pc), 32'h081);

        do_reset();
        step(); step();
        chk("id_setup_q_count", 32'(q_count), 2);
        id_is_jump = 1; id_jump_in_bht = 0; id_branchtarget = 10'h020;
        #1 chk("id_no_flush", 32'(flush), 0);
        step();
        id_is_jump = 0;
        chk("id_pc", 32'(pc), 32'h020);
        chk("id_q_count", 32'(q_count), 2);
        exe_valid = 1; exe_PC = 10'd0;
        step();
        exe_PC = 10'd2;
        step();
        exe_valid = 0;
        chk("id_replaced_trk", 32'(trk_error), 0);
        chk("id_after_pc", 32'(pc), 32'h022);

        do_reset();
        exe_valid = 1; exe_PC = '0;
        step();
        exe_valid = 0;
        chk("err_empty_pop", 32'(trk_error), 1);
        chk("err_empty_q_count", 32'(q_count), 1);
        stall = 1;
        repeat (3) step();
        stall = 0;
        chk("err_sticky", 32'(trk_error), 1);
        exe_correction = CORR_CNI; exe_CNI = 10'h3FF;
        step();
        exe_correction = 2'b00;
        chk("wrap_setup_pc", 32'(pc), 32'h3FF);
        step();
        chk("wrap_pc", 32'(pc), 0);
        do_reset();
        chk("err_cleared", 32'(trk_error), 0);
        repeat (4) step();
        chk("full_q_count", 32'(q_count), 4);
        chk("full_no_err", 32'(trk_error), 0);
        step();
        chk("overflow_err", 32'(trk_error), 1);
        chk("overflow_q_count", 32'(q_count), 4);
        do_reset();
        step();
        exe_valid = 1; exe_PC = 10'd7;
        step();
        exe_valid = 0;
        chk("mismatch_err", 32'(trk_error), 1);
        chk("mismatch_q_count", 32'(q_count), 1);

        do_reset();
        exe_correction = CORR_PBT; exe_PBT = '0;
        repeat (65536) step();
        exe_correction = 2'b00;
        chk("sat_cnt", 32'(mispredict_cnt), 32'hFFFF);
        stall = 1;
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_stall_pc", 32'(pc), 0);
        chk("rst_stall_q_count", 32'(q_count), 0);
        chk("rst_stall_flush", 32'(flush), 0);
        chk("rst_stall_cnt", 32'(mispredict_cnt), 0);

        for (int b = 0; b < 3; b++) begin
            do_reset();
            for (int n = 0; n < 800; n++) begin
                rand_inputs(b == 0);
                step();
            end
            if (b == 0) chk("clean_no_err", 32'(trk_error), 0);
        end
        idle();
        step();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
